decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Registered successor to the combinational instruction decoder.
- Accepts fetched 32-bit RV32I words with their PCs over a valid/ready handshake and decodes each word at enqueue.
- Buffers decoded micro-ops in a parametrised FIFO and presents them to the dispatcher over a second valid/ready handshake.
- Adds per-field use flags, illegal-instruction detection, a stall input and a mispredict flush. Sits between the Instruction Fetcher and the dispatcher.

Parameters:
- QUEUE_WIDTH, 2, log2 of queue depth; DEPTH = 1 << QUEUE_WIDTH entries.
- NOP_ON_FENCE, 1: 1 decodes FENCE (0001111) as addi x0,x0,0; 0 flags it illegal.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous reset, active-high.
- rdy_in  input  1  global ready; when 0, no state changes and no handshake completes.
- flush_in  input  1  mispredict flush; empties the queue.
- in_valid  input  1  fetcher offers an instruction.
- in_ready  output  1  queue can accept one instruction.
- in_inst  input  32  raw instruction word.
- in_pc  input  32  PC of in_inst.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  dispatcher consumes the head entry.
- out_op  output  7  internal op code: lui=1 ... andr=37 (existing enum); 0 when illegal.
- out_rd, out_rs1, out_rs2  output  5 each  register fields: rd=[11:7], rs1=[19:15], rs2=[24:20].
- out_imm  output  32  decoded immediate.
- out_pc  output  32  PC of the head entry.
- out_uses_rs1, out_uses_rs2, out_writes_rd  output  1 each  operand and destination use flags.
- out_illegal  output  1  head entry is an undecodable word.
- count  output  QUEUE_WIDTH+1  current occupancy.

Behaviour:
- Clock and reset: one clock (clk_in). Reset (rst_in) is synchronous and active-high; it clears head, tail and count to 0 and forces every output to 0, except in_ready, which is 1 after reset.
- Enqueue: on a rising edge with rdy_in=1 and in_valid && in_ready, decode in_inst combinationally and write the result to the tail entry; tail wraps modulo DEPTH.
- Latency: an entry accepted at edge N is visible with out_valid=1 after edge N. There is no combinational bypass from in_* to out_*.
- Dequeue: on an edge with rdy_in=1 and out_valid && out_ready, head advances (wraps modulo DEPTH). The out_* fields are driven from the head entry combinationally off registered storage.
- in_ready = (count != DEPTH). It does not depend on out_ready, so a full queue refuses input even in a cycle that dequeues.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Empty: out_valid=0. The out_* fields are don't-care except out_illegal=0.
- flush_in=1 with rdy_in=1 at an edge:
  - head=tail=count=0;
  - any same-cycle enqueue or dequeue is discarded;
  - out_valid=0 after the edge.
  - flush_in dominates all other events. rst_in dominates flush_in.
- rdy_in=0: pointers, storage and count are held. in_ready and out_valid still reflect the current state, but no transfer occurs.
- Immediate formation:
  - U-type: {inst[31:12], 12'b0}.
  - J-type and B-type: sign-extended, bit 0 = 0.
  - I-type, load and jalr: sign-extended inst[31:20].
  - S-type: sign-extended {inst[31:25], inst[11:7]}.
  - Shift-immediates: zero-extended inst[24:20].
  - R-type: 0.
- Use flags:
  - uses_rs1 = 0 for lui, auipc, jal.
  - uses_rs2 = 1 only for B, S and R types.
  - writes_rd = 0 for B and S types and whenever rd==0.
- Illegal conditions:
  - unknown major opcode;
  - unused funct3: B-type 010/011, load 011/110/111, store 1xx;
  - R-type funct7 other than 0000000, or 0100000 with funct3 000/101;
  - slli with funct7 != 0000000;
  - srli/srai with funct7 not 0000000/0100000;
  - inst[1:0] != 11.
- For an illegal word: out_op=0, out_illegal=1, all use flags 0, PC kept. The entry is still enqueued and dequeued normally; the dispatcher raises the trap.
- srai is selected only when funct7 == 0100000.

Test Plan:
- Reset, then enqueue 0x00500093 (addi x1,x0,5) at PC 0x0 -> one cycle later out_valid=1, out_op=19, out_rd=1, out_rs1=0, out_imm=5, out_uses_rs1=1, out_writes_rd=1, count=1.
- Enqueue 5 words with out_ready=0, DEPTH=4 -> in_ready=0 after the 4th acceptance and the 5th is not accepted, count=4. Then drain with out_ready=1 -> PCs emerge in order, wrap-around correct, count returns to 0.
- Hold in_valid=out_ready=1 with continuous words -> one instruction per cycle, count stays 1.
- Enqueue 0xFE000EE3 (beq x0,x0,-4) and 0x40F75793 (srai x15,x14,15) -> op 5, imm 0xFFFFFFFC, uses_rs2=1, writes_rd=0; then op 27, imm 15.
- Enqueue 0xFFFFFFFF and 0x02000033 (funct7=0000001 add) -> both out_illegal=1, out_op=0.
- Fill 3 entries, assert flush_in together with in_valid=1 -> after the edge count=0, out_valid=0, in_ready=1, and the offered word is dropped. Repeat with rdy_in=0 -> no change.

Source files
------------

// File: rtl/decode_queue.sv
// RV32I decode queue: decodes fetched words at enqueue and buffers the micro-ops in a
// DEPTH-entry FIFO for the dispatcher.
// Both ports use valid/ready: a transfer happens on a rising edge where valid && ready && rdy_in && !flush_in.
module decode_queue #(
    parameter int QUEUE_WIDTH  = 2,
    parameter bit NOP_ON_FENCE = 1'b1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [31:0]            in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6:0]             out_op,
    output logic [4:0]             out_rd,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [31:0]            out_imm,
    output logic [31:0]            out_pc,
    output logic                   out_uses_rs1,
    output logic                   out_uses_rs2,
    output logic                   out_writes_rd,
    output logic                   out_illegal,
    output logic [QUEUE_WIDTH:0]   count
);
    localparam int DEPTH = 1 << QUEUE_WIDTH;
    localparam logic [QUEUE_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [QUEUE_WIDTH:0]   CNT_ONE = 1;

    typedef enum logic [6:0] {
        OP_NONE = 7'd0, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } uop_t;

    uop_t                   mem_q [DEPTH];
    logic [QUEUE_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [QUEUE_WIDTH:0]   count_q, count_d;
    uop_t                   dec, head;
    logic                   do_enq, do_deq;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm_sh = {27'b0, in_inst[24:20]};

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rd      = in_inst[11:7];
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.op      = OP_NONE;
        dec.illegal = 1'b0;
        case (opcode)
            7'b0110111: begin dec.op = OP_LUI;   dec.imm = imm_u; dec.writes_rd = 1'b1; end
            7'b0010111: begin dec.op = OP_AUIPC; dec.imm = imm_u; dec.writes_rd = 1'b1; end
            7'b1101111: begin dec.op = OP_JAL;   dec.imm = imm_j; dec.writes_rd = 1'b1; end
            7'b1100111: begin
                dec.op = OP_JALR; dec.imm = imm_i; dec.uses_rs1 = 1'b1; dec.writes_rd = 1'b1;
            end
            7'b1100011: begin
                dec.imm = imm_b; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
                case (funct3)
                    3'b000:  dec.op = OP_BEQ;
                    3'b001:  dec.op = OP_BNE;
                    3'b100:  dec.op = OP_BLT;
                    3'b101:  dec.op = OP_BGE;
                    3'b110:  dec.op = OP_BLTU;
                    3'b111:  dec.op = OP_BGEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec.imm = imm_i; dec.uses_rs1 = 1'b1; dec.writes_rd = 1'b1;
                case (funct3)
                    3'b000:  dec.op = OP_LB;
                    3'b001:  dec.op = OP_LH;
                    3'b010:  dec.op = OP_LW;
                    3'b100:  dec.op = OP_LBU;
                    3'b101:  dec.op = OP_LHU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                dec.imm = imm_s; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
                case (funct3)
                    3'b000:  dec.op = OP_SB;
                    3'b001:  dec.op = OP_SH;
                    3'b010:  dec.op = OP_SW;
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.imm = imm_i; dec.uses_rs1 = 1'b1; dec.writes_rd = 1'b1;
                case (funct3)
                    3'b000: dec.op = OP_ADDI;
                    3'b010: dec.op = OP_SLTI;
                    3'b011: dec.op = OP_SLTIU;
                    3'b100: dec.op = OP_XORI;
                    3'b110: dec.op = OP_ORI;
                    3'b111: dec.op = OP_ANDI;
                    3'b001: begin
                        dec.imm = imm_sh;
                        if (funct7 == 7'b0000000) dec.op = OP_SLLI;
                        else                      dec.illegal = 1'b1;
                    end
                    3'b101: begin
                        dec.imm = imm_sh;
                        if (funct7 == 7'b0000000)      dec.op = OP_SRLI;
                        else if (funct7 == 7'b0100000) dec.op = OP_SRAI;
                        else                           dec.illegal = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.writes_rd = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: dec.op = OP_ADD;
                        3'b001: dec.op = OP_SLL;
                        3'b010: dec.op = OP_SLT;
                        3'b011: dec.op = OP_SLTU;
                        3'b100: dec.op = OP_XOR;
                        3'b101: dec.op = OP_SRL;
                        3'b110: dec.op = OP_OR;
                        3'b111: dec.op = OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.op = OP_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.op = OP_SRA;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0001111: begin
                // FENCE has no ordering effect in this in-order core: becomes addi x0,x0,0
                if (NOP_ON_FENCE) begin
                    dec.op = OP_ADDI; dec.rd = '0; dec.rs1 = '0; dec.rs2 = '0; dec.uses_rs1 = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.op = OP_NONE; dec.uses_rs1 = 1'b0; dec.uses_rs2 = 1'b0; dec.writes_rd = 1'b0;
        end
        if (dec.rd == 5'd0) dec.writes_rd = 1'b0;
    end

    assign in_ready  = ~count_q[QUEUE_WIDTH];
    assign out_valid = (count_q != '0);
    assign do_enq    = rdy_in & ~flush_in & in_valid & in_ready;
    assign do_deq    = rdy_in & ~flush_in & out_valid & out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in && flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_enq) tail_d = tail_q + PTR_ONE;
            if (do_deq) head_d = head_q + PTR_ONE;
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; outputs are masked whenever the queue is empty.
    always_ff @(posedge clk_in) begin
        if (do_enq && !rst_in) mem_q[tail_q] <= dec;
    end

    assign head          = out_valid ? mem_q[head_q] : '0;
    assign out_op        = head.op;
    assign out_rd        = head.rd;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_imm       = head.imm;
    assign out_pc        = head.pc;
    assign out_uses_rs1  = head.uses_rs1;
    assign out_uses_rs2  = head.uses_rs2;
    assign out_writes_rd = head.writes_rd;
    assign out_illegal   = head.illegal;
    assign count         = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed words, expected micro-ops queued at acceptance and
// checked by an output monitor whenever the dispatcher side completes a transfer.
module tb_decode_queue;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_imm, out_pc;
    logic [6:0]  out_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [89:0] exp_q[$];
    logic [31:0] v_inst [12];
    logic [89:0] v_exp  [12];

    decode_queue #(.QUEUE_WIDTH(2), .NOP_ON_FENCE(1'b1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc),
        .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
        .out_writes_rd(out_writes_rd), .out_illegal(out_illegal), .count(count)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [89:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                       input logic [31:0] imm, input logic [31:0] pc,
                                       input logic u1, input logic u2, input logic wr, input logic ill);
        logic [6:0] o;
        logic [4:0] d, s1, s2;
        o = op[6:0]; d = rd[4:0]; s1 = rs1[4:0]; s2 = rs2[4:0];
        return {o, d, s1, s2, imm, pc, u1, u2, wr, ill};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s act=timeout exp=handshake", name);
    endtask

    // scoreboard monitor: illegal entries are compared on op, pc, flags and illegal only
    always @(negedge clk_in) begin
        logic [89:0] act, e, mask;
        if (!rst_in && rdy_in) begin
            if (flush_in) begin
                exp_q.delete();
            end else if (out_valid && out_ready) begin
                act = {out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc,
                       out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal};
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", act, '0);
                end else begin
                    e = exp_q.pop_front();
                    mask = e[0] ? {7'h7f, 15'h0, 32'h0, 32'hffffffff, 4'hf} : '1;
                    chk("out_entry", act & mask, e & mask);
                end
            end
        end
    end

    // driver tasks
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [89:0] e);
        int n = 0;
        in_inst  = inst;
        in_pc    = pc;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk_in);
            if (in_ready && rdy_in && !flush_in) begin
                exp_q.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                fail_now("send_timeout");
                break;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk_in);
        while (count != 0 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        chk("drain_count", count, 0);
        chk("drain_scoreboard", exp_q.size(), 0);
        @(posedge clk_in);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        v_inst[0]  = 32'h00500093; v_exp[0]  = mk(19, 1, 0, 5, 32'h5, 32'h200, 1, 0, 1, 0);
        v_inst[1]  = 32'h123452B7; v_exp[1]  = mk(1, 5, 8, 3, 32'h12345000, 32'h204, 0, 0, 1, 0);
        v_inst[2]  = 32'h00208133; v_exp[2]  = mk(28, 2, 1, 2, 32'h0, 32'h208, 1, 1, 1, 0);
        v_inst[3]  = 32'h40208133; v_exp[3]  = mk(29, 2, 1, 2, 32'h0, 32'h20C, 1, 1, 1, 0);
        v_inst[4]  = 32'h0080006F; v_exp[4]  = mk(3, 0, 0, 8, 32'h8, 32'h210, 0, 0, 0, 0);
        v_inst[5]  = 32'hFFC12083; v_exp[5]  = mk(13, 1, 2, 28, 32'hFFFFFFFC, 32'h214, 1, 0, 1, 0);
        v_inst[6]  = 32'h00112623; v_exp[6]  = mk(18, 12, 2, 1, 32'hC, 32'h218, 1, 1, 0, 0);
        v_inst[7]  = 32'h0FF0000F; v_exp[7]  = mk(19, 0, 0, 0, 32'h0, 32'h21C, 1, 0, 0, 0);
        v_inst[8]  = 32'hFE000EE3; v_exp[8]  = mk(5, 29, 0, 0, 32'hFFFFFFFC, 32'h220, 1, 1, 0, 0);
        v_inst[9]  = 32'h40F75793; v_exp[9]  = mk(27, 15, 14, 15, 32'hF, 32'h224, 1, 0, 1, 0);
        v_inst[10] = 32'hFFFFFFFF; v_exp[10] = mk(0, 0, 0, 0, 32'h0, 32'h228, 0, 0, 0, 1);
        v_inst[11] = 32'h02000033; v_exp[11] = mk(0, 0, 0, 0, 32'h0, 32'h22C, 0, 0, 0, 1);

        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_out_op", out_op, 0);
        @(posedge clk_in); #1;

        // single addi, one-cycle latency
        send(32'h00500093, 32'h0, mk(19, 1, 0, 5, 32'h5, 32'h0, 1, 0, 1, 0));
        idle();
        @(negedge clk_in);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_count", count, 1);
        chk("t1_out_op", out_op, 19);
        @(posedge clk_in); #1;
        drain();

        // fill past full, then drain across the wrap
        for (int i = 0; i < 4; i++)
            send(32'h00500093, 32'h100 + 4 * i, mk(19, 1, 0, 5, 32'h5, 32'h100 + 4 * i, 1, 0, 1, 0));
        in_inst = 32'h00500093;
        in_pc   = 32'h110;
        @(negedge clk_in);
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 4);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("full_refused_count", count, 4);
        @(posedge clk_in); #1;
        idle();
        drain();

        // back-to-back stream, including branch, srai and illegal words
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(v_inst[i], 32'h200 + 4 * i, v_exp[i]);
            chk("stream_count", count, 1);
        end
        idle();
        drain();

        // flush with a same-cycle offered word
        for (int i = 0; i < 3; i++)
            send(32'h00500093, 32'h300 + 4 * i, mk(19, 1, 0, 5, 32'h5, 32'h300 + 4 * i, 1, 0, 1, 0));
        in_inst  = 32'h00500093;
        in_pc    = 32'h3FC;
        flush_in = 1'b1;
        @(posedge clk_in); #1;
        flush_in = 1'b0;
        idle();
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        @(posedge clk_in); #1;
        chk("flush_dropped_count", count, 0);

        // flush while rdy_in=0 has no effect
        for (int i = 0; i < 3; i++)
            send(32'h00500093, 32'h400 + 4 * i, mk(19, 1, 0, 5, 32'h5, 32'h400 + 4 * i, 1, 0, 1, 0));
        in_pc    = 32'h4FC;
        rdy_in   = 1'b0;
        flush_in = 1'b1;
        out_ready = 1'b1;
        @(posedge clk_in); #1;
        chk("hold_count", count, 3);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_out_pc", out_pc, 32'h400);
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        out_ready = 1'b0;
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
